// File: rtl/bk_serial_adder.sv
// Serial wide adder: feeds one 4-bit slice per cycle through a Brent-Kung slice, LSB first.
// Define BK_SERIAL_OVF_EN to add a registered signed-overflow output `ovf`.

module Brentkung (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p, c;
  logic       g10, p10, g32, p32, g20, p20, g30, p30;

  always_comb begin
    g   = a & b;
    p   = a ^ b;
    // Up-sweep of the prefix tree, then the single down-sweep node for bit 2.
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;
    g20 = g[2] | (p[2] & g10);
    p20 = p[2] & p10;
    c    = {g20 | (p20 & cin), g10 | (p10 & cin), g[0] | (p[0] & cin), cin};
    s    = p ^ c;
    cout = g30 | (p30 & cin);
  end
endmodule

module bk_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef BK_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic               out_valid_q, out_valid_d, busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         slice_a, slice_b, slice_s;
  logic               slice_cout;
  logic               last_slice;

  assign slice_a    = a_q[{idx_q, 2'b00} +: 4];
  assign slice_b    = b_q[{idx_q, 2'b00} +: 4];
  assign last_slice = (idx_q == IDX_W'(N - 1));

  Brentkung u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        idx_d   = '0;
        sum_d   = '0;
        ovf_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d = slice_cout;
        if (last_slice) begin
          cout_d      = slice_cout;
          ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers are reset too, so a mid-operation reset leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef BK_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ ovf_d;
`endif
endmodule

// File: tb/tb_bk_serial_adder.sv
// Bench for bk_serial_adder: directed vectors, a cycle-level reference model and a compare process.
// Covers WIDTH=16 and WIDTH=4; ovf checks are included when BK_SERIAL_OVF_EN is defined.

module tb_bk_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin;
  logic [15:0] a, b;
  logic        in_ready, out_valid, busy, cout;
  logic [15:0] sum;
  logic        in_valid4, cin4;
  logic [3:0]  a4, b4;
  logic        in_ready4, out_valid4, busy4, cout4;
  logic [3:0]  sum4;
`ifdef BK_SERIAL_OVF_EN
  logic        ovf, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bk_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef BK_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  bk_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(1'b1),
    .sum(sum4), .cout(cout4),
`ifdef BK_SERIAL_OVF_EN
    .ovf(ovf4),
`endif
    .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the result is a+b+cin, ready 4 edges after acceptance, held until taken.
  int          m_rem;
  logic        m_valid;
  logic [16:0] m_res;
  logic        m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_valid <= 1'b0; m_res <= '0; m_ovf <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_valid <= 1'b1;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (in_valid) begin
      m_rem <= 4;
      m_res <= {1'b0, a} + {1'b0, b} + 17'(cin);
      m_ovf <= (a[15] == b[15]) && (((a + b + 16'(cin)) >> 15) != 16'(a[15]));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready", 32'(in_ready), 32'(m_rem == 0 && !m_valid));
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_busy", 32'(busy), 32'(m_rem != 0));
      if (m_rem == 0) begin
        check("model_sum", 32'(sum), 32'(m_res[15:0]));
        check("model_cout", 32'(cout), 32'(m_res[16]));
`ifdef BK_SERIAL_OVF_EN
        check("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("issue_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ia; b = ib; cin = ic;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!out_valid) check("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int   lat, k;
    time  t0, t1;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst4_in_ready", 32'(in_ready4), 32'd1);
    #3 rst_n = 1'b1;

    // Carry ripples through every slice.
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_sum", 32'(sum), 32'h0000);
    check("t1_cout", 32'(cout), 32'd1);

    // Back-to-back: second op held on the inputs, accepted 6 cycles after the first.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1 a = 16'h8000; b = 16'h8000; cin = 1'b0;
    seen = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        check("t2_sum", 32'(sum), 32'h5556);
        check("t2_cout", 32'(cout), 32'd0);
      end
      if (in_ready) break;
      k++;
    end
    @(posedge clk);
    t1 = $time;
    #1 in_valid = 1'b0;
    check("t2_seen_result", 32'(seen), 32'd1);
    check("t2_accept_gap", 32'((t1 - t0) / 10), 32'd6);
    wait_valid(lat);
    check("t2b_sum", 32'(sum), 32'h0000);
    check("t2b_cout", 32'(cout), 32'd1);

    // Backpressure with ignored operands.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(16'h00F0, 16'h0010, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 16'(i * 16'h1111); b = 16'h0FFF; cin = 1'b1;
      @(posedge clk); #1;
      check("bp_sum", 32'(sum), 32'h0100);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'(out_valid), 32'd0);

    // Reset after the third slice index has been reached.
    issue(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    issue(16'h0003, 16'h0004, 1'b0);
    wait_valid(lat);
    check("post_rst_sum", 32'(sum), 32'h0007);

`ifdef BK_SERIAL_OVF_EN
    issue(16'h7FFF, 16'h0001, 1'b0);
    wait_valid(lat);
    check("ovf_pos_sum", 32'(sum), 32'h8000);
    check("ovf_pos_cout", 32'(cout), 32'd0);
    check("ovf_pos", 32'(ovf), 32'd1);
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(lat);
    check("ovf_neg", 32'(ovf), 32'd0);
`endif

    // A few unconstrained vectors, checked by the model.
    for (int i = 0; i < 6; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom));
      wait_valid(lat);
    end

    // WIDTH=4: a single RUN cycle.
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    check("w4_busy", 32'(busy4), 32'd1);
    check("w4_not_yet", 32'(out_valid4), 32'd0);
    @(posedge clk); #1;
    check("w4_out_valid", 32'(out_valid4), 32'd1);
    check("w4_sum", 32'(sum4), 32'h1);
    check("w4_cout", 32'(cout4), 32'd1);
    @(posedge clk); #1;
    check("w4_idle", 32'(in_ready4), 32'd1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
